sm_reg_scanner: RTL

SM_REG_SCANNER -- requirements
Module: sm_reg_scanner

---
 rtl/sm_reg_scanner.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sm_reg_scanner.sv
// sm_reg_scanner
// Steps a 5-bit debug read address through [REG_FIRST, REG_LAST], captures
// the CPU register word returned for it and presents it one halfword at a time
// for a 4-digit hex display. MANUAL mode advances on btn_next; AUTO mode
// advances every DWELL cycles (btn_next still forces an early step).
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   btn_next   in   debounced "next register" level
//   btn_mode   in   debounced "manual/auto toggle" level
//   regData    in   [31:0] debug read data, combinational from regAddr
//   regAddr    out  [4:0]  registered debug read address
//   display    out  [15:0] selected halfword of the captured word
//   addr_show  out  [4:0]  address the captured word belongs to
//   half       out  0 = bits [15:0] shown, 1 = bits [31:16] shown
//   auto_mode  out  1 while in AUTO
module sm_reg_scanner #(
    parameter logic [4:0]  REG_FIRST   = 5'd0,
    parameter logic [4:0]  REG_LAST    = 5'd31,
    parameter logic [23:0] DWELL       = 24'd12000000,
    parameter logic [23:0] HALF_CYCLES = 24'd3000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_mode,
    input  logic [31:0] regData,
    output logic [4:0]  regAddr,
    output logic [15:0] display,
    output logic [4:0]  addr_show,
    output logic        half,
    output logic        auto_mode
);

    // Counters only ever reach DWELL-1 / HALF_CYCLES-1.
    localparam int DW_W = (DWELL > 24'd1) ? $clog2(DWELL) : 1;
    localparam int HC_W = (HALF_CYCLES > 24'd1) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL - 24'd1);
    localparam logic [HC_W-1:0] HALF_MAX  = HC_W'(HALF_CYCLES - 24'd1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      addr_q, addr_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [HC_W-1:0] hcnt_q, hcnt_d;
    logic            half_q, half_d;
    logic [31:0]     capture_q, capture_d;
    logic [4:0]      addr_show_q, addr_show_d;
    logic            next_prev_q, next_prev_d;
    logic            mode_prev_q, mode_prev_d;

    logic next_edge, mode_edge, advance;

    always_comb begin
        next_edge   = btn_next & ~next_prev_q;
        mode_edge   = btn_mode & ~mode_prev_q;
        state_d     = state_q;
        addr_d      = addr_q;
        dwell_d     = dwell_q;
        hcnt_d      = hcnt_q;
        half_d      = half_q;
        advance     = 1'b0;
        next_prev_d = btn_next;
        mode_prev_d = btn_mode;
        // Capture and its address move together so the pair always matches.
        capture_d   = regData;
        addr_show_d = addr_q;

        // A mode edge wins over a simultaneous next edge and never steps.
        if (mode_edge) begin
            state_d = (state_q == ST_AUTO) ? ST_MANUAL : ST_AUTO;
            dwell_d = '0;
        end else if (state_q == ST_AUTO) begin
            if (next_edge || dwell_q == DWELL_MAX) begin
                advance = 1'b1;
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end else if (next_edge) begin
            advance = 1'b1;
        end

        // A new register always starts on its low halfword.
        if (advance) begin
            addr_d  = (addr_q == REG_LAST) ? REG_FIRST : addr_q + 5'd1;
            dwell_d = '0;
            half_d  = 1'b0;
            hcnt_d  = '0;
        end else if (hcnt_q == HALF_MAX) begin
            half_d = ~half_q;
            hcnt_d = '0;
        end else begin
            hcnt_d = hcnt_q + HC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_MANUAL;
            addr_q      <= REG_FIRST;
            dwell_q     <= '0;
            hcnt_q      <= '0;
            half_q      <= 1'b0;
            capture_q   <= 32'h0;
            addr_show_q <= REG_FIRST;
            // Held high so a button pressed through reset gives no edge.
            next_prev_q <= 1'b1;
            mode_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dwell_q     <= dwell_d;
            hcnt_q      <= hcnt_d;
            half_q      <= half_d;
            capture_q   <= capture_d;
            addr_show_q <= addr_show_d;
            next_prev_q <= next_prev_d;
            mode_prev_q <= mode_prev_d;
        end
    end

    assign regAddr   = addr_q;
    assign addr_show = addr_show_q;
    assign half      = half_q;
    assign auto_mode = (state_q == ST_AUTO);
    assign display   = half_q ? capture_q[31:16] : capture_q[15:0];

endmodule
